// File: rtl/srff_bank.sv
// Bank of independent clocked SR flip-flops with edge pulses, population count
// and a sticky flag recording any S=R=1 request on an enabled channel.
module srff_bank #(
  parameter int               WIDTH   = 4,
  parameter int               SR_MODE = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         srff_clk,
  input  logic                         srff_rst_b,
  input  logic [WIDTH-1:0]             srff_en_i,
  input  logic [WIDTH-1:0]             srff_S_i,
  input  logic [WIDTH-1:0]             srff_R_i,
  input  logic                         srff_clr_i,
  output logic [WIDTH-1:0]             srff_Q_o,
  output logic [WIDTH-1:0]             srff_Qb_o,
  output logic [WIDTH-1:0]             srff_rise_o,
  output logic [WIDTH-1:0]             srff_fall_o,
  output logic [$clog2(WIDTH+1)-1:0]   srff_cnt_o,
  output logic                         srff_any_o,
  output logic                         srff_conflict_o
);

  localparam int CNT_W = $clog2(WIDTH+1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict_q, conflict_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic sr_next(input logic q, input logic s, input logic r);
    logic n;
    n = q;
    if (s && !r)      n = 1'b1;
    else if (!s && r) n = 1'b0;
    else if (s && r) begin
      if (SR_MODE == 1)      n = 1'b1;
      else if (SR_MODE == 2) n = 1'b0;
      else if (SR_MODE == 3) n = ~q;
      else                   n = q;
    end
    return n;
  endfunction

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (srff_en_i[i]) q_d[i] = sr_next(q_q[i], srff_S_i[i], srff_R_i[i]);
    end
    if (srff_clr_i) q_d = RST_VAL;
    // Pulses compare the present state against the state about to be loaded.
    rise_d = ~q_q & q_d;
    fall_d = q_q & ~q_d;
    cnt_d  = popcount(q_q);
    if (srff_clr_i) conflict_d = 1'b0;
    else            conflict_d = conflict_q | (|(srff_en_i & srff_S_i & srff_R_i));
  end

  always_ff @(posedge srff_clk or negedge srff_rst_b) begin
    if (!srff_rst_b) begin
      q_q        <= RST_VAL;
      rise_q     <= '0;
      fall_q     <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign srff_Q_o        = q_q;
  assign srff_Qb_o       = ~q_q;
  assign srff_rise_o     = rise_q;
  assign srff_fall_o     = fall_q;
  assign srff_cnt_o      = cnt_q;
  assign srff_any_o      = |q_q;
  assign srff_conflict_o = conflict_q;

endmodule

// File: tb/tb_srff_bank.sv
// Bench for srff_bank: four instances (one per SR_MODE) share stimulus and are
// compared against a behavioural model of the bank.
module tb_srff_bank;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic [3:0] en = '0, s = '0, r = '0;
  logic       clr = 1'b0;

  logic [3:0] q_o[4], qb_o[4], rise_o[4], fall_o[4];
  logic [2:0] cnt_o[4];
  logic       any_o[4], conf_o[4];

  logic [3:0] mq[4], mrise[4], mfall[4];
  int         mcnt[4];
  logic       mconf[4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  genvar gm;
  generate
    for (gm = 0; gm < 4; gm++) begin : g_dut
      srff_bank #(.WIDTH(4), .SR_MODE(gm), .RST_VAL(4'b0000)) u_dut (
        .srff_clk        (clk),
        .srff_rst_b      (rst_b),
        .srff_en_i       (en),
        .srff_S_i        (s),
        .srff_R_i        (r),
        .srff_clr_i      (clr),
        .srff_Q_o        (q_o[gm]),
        .srff_Qb_o       (qb_o[gm]),
        .srff_rise_o     (rise_o[gm]),
        .srff_fall_o     (fall_o[gm]),
        .srff_cnt_o      (cnt_o[gm]),
        .srff_any_o      (any_o[gm]),
        .srff_conflict_o (conf_o[gm])
      );
    end
  endgenerate

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      mq[m] = 4'b0000; mrise[m] = '0; mfall[m] = '0; mcnt[m] = 0; mconf[m] = 1'b0;
    end
  endtask

  // Behavioural model of one clock edge, from the channel rules.
  task automatic model_edge();
    logic [3:0] nq;
    if (!rst_b) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 4; i++) begin
        nq[i] = mq[m][i];
        if (clr) nq[i] = 1'b0;
        else if (en[i]) begin
          if (s[i] && !r[i])      nq[i] = 1'b1;
          else if (r[i] && !s[i]) nq[i] = 1'b0;
          else if (s[i] && r[i]) begin
            case (m)
              1: nq[i] = 1'b1;
              2: nq[i] = 1'b0;
              3: nq[i] = !mq[m][i];
              default: nq[i] = mq[m][i];
            endcase
          end
        end
      end
      mcnt[m]  = $countones(mq[m]);
      mrise[m] = 4'b0000;
      mfall[m] = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (mq[m][i] == 1'b0 && nq[i] == 1'b1) mrise[m][i] = 1'b1;
        if (mq[m][i] == 1'b1 && nq[i] == 1'b0) mfall[m][i] = 1'b1;
      end
      if (clr) mconf[m] = 1'b0;
      else if ((en & s & r) != 4'b0000) mconf[m] = 1'b1;
      mq[m] = nq;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1; en = '0; s = '0; r = '0;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_b = 1'b0;
    model_reset();
    #2;
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (q_o[m] !== 4'b0000) begin n_err++; $display("FAIL rst_q m%0d got %b expected 0000", m, q_o[m]); end
      n_vec++; if (qb_o[m] !== 4'b1111) begin n_err++; $display("FAIL rst_qb m%0d got %b expected 1111", m, qb_o[m]); end
      n_vec++; if (cnt_o[m] !== 3'd0) begin n_err++; $display("FAIL rst_cnt m%0d got %0d expected 0", m, cnt_o[m]); end
      n_vec++; if (conf_o[m] !== 1'b0) begin n_err++; $display("FAIL rst_conf m%0d got %b expected 0", m, conf_o[m]); end
    end
    step();
    rst_b = 1'b1;
    en = 4'b1111; s = 4'b1011; r = 4'b0000;
    step();
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (q_o[m] !== 4'b1011) begin n_err++; $display("FAIL pre_rst_q m%0d got %b expected 1011", m, q_o[m]); end
    end
    #2 rst_b = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (q_o[m] !== 4'b0000) begin n_err++; $display("FAIL mid_rst_q m%0d got %b expected 0000", m, q_o[m]); end
      n_vec++; if (qb_o[m] !== 4'b1111) begin n_err++; $display("FAIL mid_rst_qb m%0d got %b expected 1111", m, qb_o[m]); end
      n_vec++; if (cnt_o[m] !== 3'd0) begin n_err++; $display("FAIL mid_rst_cnt m%0d got %0d expected 0", m, cnt_o[m]); end
      n_vec++; if (conf_o[m] !== 1'b0 || any_o[m] !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags m%0d got conf=%b any=%b expected 0 0", m, conf_o[m], any_o[m]); end
      n_vec++; if (rise_o[m] !== 4'b0000 || fall_o[m] !== 4'b0000) begin n_err++; $display("FAIL mid_rst_pulse m%0d got rise=%b fall=%b expected 0", m, rise_o[m], fall_o[m]); end
    end
    step();
    rst_b = 1'b1;
    en = '0; s = '0; r = '0;
    step();
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (rise_o[m] !== 4'b0000 || fall_o[m] !== 4'b0000) begin n_err++; $display("FAIL rel_pulse m%0d got rise=%b fall=%b expected 0", m, rise_o[m], fall_o[m]); end
      n_vec++; if (q_o[m] !== 4'b0000 || cnt_o[m] !== 3'd0) begin n_err++; $display("FAIL rel_state m%0d got q=%b cnt=%0d expected 0 0", m, q_o[m], cnt_o[m]); end
    end
  endtask

  task automatic test_set();
    do_clear();
    en = 4'b1111; s = 4'b0101; r = 4'b0000;
    step();
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (q_o[m] !== 4'b0101) begin n_err++; $display("FAIL set_q m%0d got %b expected 0101", m, q_o[m]); end
      n_vec++; if (rise_o[m] !== 4'b0101) begin n_err++; $display("FAIL set_rise m%0d got %b expected 0101", m, rise_o[m]); end
      n_vec++; if (any_o[m] !== 1'b1) begin n_err++; $display("FAIL set_any m%0d got %b expected 1", m, any_o[m]); end
    end
    en = '0;
    step();
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (rise_o[m] !== 4'b0000) begin n_err++; $display("FAIL set_rise_end m%0d got %b expected 0000", m, rise_o[m]); end
      n_vec++; if (cnt_o[m] !== 3'd2) begin n_err++; $display("FAIL set_cnt m%0d got %0d expected 2", m, cnt_o[m]); end
    end
  endtask

  task automatic test_enable();
    do_clear();
    en = 4'b0011; s = 4'b1111; r = 4'b0000;
    step();
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (q_o[m] !== 4'b0011) begin n_err++; $display("FAIL en_q m%0d got %b expected 0011", m, q_o[m]); end
    end
    s = 4'b0000; r = 4'b0001;
    step();
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (q_o[m] !== 4'b0010) begin n_err++; $display("FAIL en_rq m%0d got %b expected 0010", m, q_o[m]); end
      n_vec++; if (fall_o[m] !== 4'b0001) begin n_err++; $display("FAIL en_fall m%0d got %b expected 0001", m, fall_o[m]); end
    end
  endtask

  task automatic test_conflict();
    logic [2:0] qexp[4];
    qexp[0] = 3'b000; qexp[1] = 3'b111; qexp[2] = 3'b000; qexp[3] = 3'b101;
    do_clear();
    en = 4'b0001; s = 4'b0001; r = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      for (int m = 0; m < 4; m++) begin
        n_vec++; if (q_o[m] !== {3'b000, qexp[m][k]}) begin n_err++; $display("FAIL sr_q m%0d edge%0d got %b expected %b", m, k, q_o[m], {3'b000, qexp[m][k]}); end
        n_vec++; if (conf_o[m] !== 1'b1) begin n_err++; $display("FAIL sr_conf m%0d edge%0d got %b expected 1", m, k, conf_o[m]); end
      end
      n_vec++; if (rise_o[3] !== {3'b000, k != 1}) begin n_err++; $display("FAIL tog_rise edge%0d got %b expected %b", k, rise_o[3], {3'b000, k != 1}); end
      n_vec++; if (fall_o[3] !== {3'b000, k == 1}) begin n_err++; $display("FAIL tog_fall edge%0d got %b expected %b", k, fall_o[3], {3'b000, k == 1}); end
    end
  endtask

  task automatic test_clear();
    do_clear();
    en = 4'b1111; s = 4'b1111; r = 4'b0000;
    step();
    en = 4'b0001; s = 4'b0001; r = 4'b0001;
    step();
    en = 4'b1111; s = 4'b1111; r = 4'b0000;
    step();
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (q_o[m] !== 4'b1111 || conf_o[m] !== 1'b1) begin n_err++; $display("FAIL clr_pre m%0d got q=%b conf=%b expected 1111 1", m, q_o[m], conf_o[m]); end
    end
    clr = 1'b1; r = 4'b0001;
    step();
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (q_o[m] !== 4'b0000) begin n_err++; $display("FAIL clr_q m%0d got %b expected 0000", m, q_o[m]); end
      n_vec++; if (fall_o[m] !== 4'b1111) begin n_err++; $display("FAIL clr_fall m%0d got %b expected 1111", m, fall_o[m]); end
      n_vec++; if (conf_o[m] !== 1'b0) begin n_err++; $display("FAIL clr_conf m%0d got %b expected 0", m, conf_o[m]); end
    end
    clr = 1'b0; en = '0; s = '0; r = '0;
    step();
    for (int m = 0; m < 4; m++) begin
      n_vec++; if (cnt_o[m] !== 3'd0 || fall_o[m] !== 4'b0000) begin n_err++; $display("FAIL clr_post m%0d got cnt=%0d fall=%b expected 0 0000", m, cnt_o[m], fall_o[m]); end
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 10000; c++) begin
      if (!rst_b) rst_b = 1'b1;
      else if ($urandom_range(0, 399) == 0) begin
        rst_b = 1'b0;
        model_reset();
      end
      en  = 4'($urandom);
      s   = 4'($urandom);
      r   = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      step();
      for (int m = 0; m < 4; m++) begin
        n_vec++; if (q_o[m] !== mq[m]) begin n_err++; $display("FAIL rnd_q c%0d m%0d got %b expected %b", c, m, q_o[m], mq[m]); end
        n_vec++; if (qb_o[m] !== ~mq[m]) begin n_err++; $display("FAIL rnd_qb c%0d m%0d got %b expected %b", c, m, qb_o[m], ~mq[m]); end
        n_vec++; if (rise_o[m] !== mrise[m]) begin n_err++; $display("FAIL rnd_rise c%0d m%0d got %b expected %b", c, m, rise_o[m], mrise[m]); end
        n_vec++; if (fall_o[m] !== mfall[m]) begin n_err++; $display("FAIL rnd_fall c%0d m%0d got %b expected %b", c, m, fall_o[m], mfall[m]); end
        n_vec++; if (cnt_o[m] !== 3'(mcnt[m])) begin n_err++; $display("FAIL rnd_cnt c%0d m%0d got %0d expected %0d", c, m, cnt_o[m], mcnt[m]); end
        n_vec++; if (any_o[m] !== (mq[m] != 4'b0000)) begin n_err++; $display("FAIL rnd_any c%0d m%0d got %b expected %b", c, m, any_o[m], mq[m] != 4'b0000); end
        n_vec++; if (conf_o[m] !== mconf[m]) begin n_err++; $display("FAIL rnd_conf c%0d m%0d got %b expected %b", c, m, conf_o[m], mconf[m]); end
      end
    end
    rst_b = 1'b1;
    clr = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_set();
    test_enable();
    test_conflict();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/srff_bank.md
SRFF_BANK -- requirements
Module: srff_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of independent SR channels (1..32).
REQ-002 Parameter SR_MODE, default 0, action on S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
REQ-003 Parameter RST_VAL, default all-zero, WIDTH-bit value loaded into Q on reset and clear.
REQ-004 srff_clk  input  1  single clock, all state updates on rising edge.
REQ-005 srff_rst_b  input  1  reset, asynchronous, active-low.
REQ-006 srff_en_i  input  WIDTH  per-channel enable.
REQ-007 srff_S_i  input  WIDTH  per-channel set.
REQ-008 srff_R_i  input  WIDTH  per-channel reset.
REQ-009 srff_clr_i  input  1  synchronous clear of whole bank.
REQ-010 srff_Q_o  output  WIDTH  registered channel state.
REQ-011 srff_Qb_o  output  WIDTH  bitwise complement of srff_Q_o, combinational.
REQ-012 srff_rise_o  output  WIDTH  registered one-cycle pulse, channel went 0->1.
REQ-013 srff_fall_o  output  WIDTH  registered one-cycle pulse, channel went 1->0.
REQ-014 srff_cnt_o  output  $clog2(WIDTH+1)  registered population count of srff_Q_o.
REQ-015 srff_any_o  output  1  OR-reduction of srff_Q_o, combinational.
REQ-016 srff_conflict_o  output  1  sticky flag, S=R=1 seen on an enabled channel.

Function
REQ-017 Per channel i, en=0: Q[i] shall hold.
REQ-018 en=1, S=0 R=0: hold; S=1 R=0: Q[i]<=1; S=0 R=1: Q[i]<=0.
REQ-019 en=1, S=1 R=1: Q[i] shall follow SR_MODE (hold / 1 / 0 / ~Q[i]).
REQ-020 srff_clr_i=1 shall load RST_VAL into Q at the next edge, overriding en/S/R on every channel.
REQ-021 Rise/fall pulses shall be computed from current Q vs next Q on the same edge: rise[i]<=~Q[i]&Qn[i], fall[i]<=Q[i]&~Qn[i]; pulses coincide with the first cycle the new Q is visible and last exactly one cycle.
REQ-022 Toggle mode with S=R=1 held on an enabled channel shall alternate rise and fall pulses every cycle.
REQ-023 A clear that changes Q shall produce rise/fall pulses like any other transition.
REQ-024 srff_cnt_o shall equal popcount(Q) with one cycle latency, i.e. popcount of the Q value present in the previous cycle.
REQ-025 srff_conflict_o shall set at the edge after any channel has en=S=R=1 (all SR_MODE values) and stay set until clr_i or reset; clr_i and a new conflict in the same cycle shall leave it clear.
REQ-026 No combinational path from any input to srff_Q_o, rise, fall, cnt or conflict.

Reset
REQ-027 srff_rst_b low shall immediately (no clock) force Q=RST_VAL, rise=0, fall=0, cnt=0, conflict=0; Qb and any shall follow Q.
REQ-028 Reset asserted mid-operation shall discard pending updates; no rise/fall pulse shall be generated by reset or its release.
REQ-029 First edge after release shall evaluate inputs normally; cnt shall reflect popcount(RST_VAL) one edge after release.

Verification (WIDTH=4, RST_VAL=0)
REQ-030 Reset low mid-cycle with Q=4'b1011 -> Q=0, Qb=4'b1111, cnt=0, conflict=0 before next edge; no pulses after release.
REQ-031 en=4'b1111, S=4'b0101, R=0 -> next cycle Q=4'b0101, rise=4'b0101 for one cycle; cnt=2 a cycle later; any=1.
REQ-032 en=4'b0011, S=4'b1111, R=0 from Q=0 -> Q=4'b0011 only; then en=4'b0011, R=4'b0001 -> Q=4'b0010, fall=4'b0001.
REQ-033 S=R=4'b0001, en=4'b0001, three edges, per SR_MODE 0/1/2/3 from Q=0 -> Q[0] 0,0,0 / 1,1,1 / 0,0,0 / 1,0,1; conflict=1 after first edge in all modes.
REQ-034 Q=4'b1111, clr_i=1 with S=4'b1111 en=4'b1111 -> Q=0, fall=4'b1111, conflict cleared; cnt=0 one cycle later.
REQ-035 Random en/S/R for 10k cycles across all SR_MODE values -> Q, pulses, cnt, conflict match reference model every cycle.
